// File: rtl/uart_baud_gen_frac_if.sv
// Control/status bundle for the fractional baud generator.
//   en          : generator enable
//   sync        : one-cycle pulse restarting the tick phase
//   div_in      : new divisor, integer:fraction fixed point
//   div_load    : strobe capturing div_in into the shadow register
//   os_tick     : one-cycle oversample tick
//   bit_tick    : one-cycle tick on the last oversample of a bit
//   mid_tick    : one-cycle tick at the mid-bit sample point
//   cfg_pending : shadow divisor waiting to be applied
//   div_active  : divisor currently in use
// master drives the controls (UART/host side), slave is the generator.
interface uart_baud_gen_frac_if #(
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned FRAC_BITS = 4
);
  logic                           en;
  logic                           sync;
  logic [DIV_WIDTH+FRAC_BITS-1:0] div_in;
  logic                           div_load;
  logic                           os_tick;
  logic                           bit_tick;
  logic                           mid_tick;
  logic                           cfg_pending;
  logic [DIV_WIDTH+FRAC_BITS-1:0] div_active;

  modport master (
    output en, sync, div_in, div_load,
    input  os_tick, bit_tick, mid_tick, cfg_pending, div_active
  );

  modport slave (
    input  en, sync, div_in, div_load,
    output os_tick, bit_tick, mid_tick, cfg_pending, div_active
  );
endinterface

// File: rtl/uart_baud_gen_frac.sv
// Programmable fractional baud-rate generator.
// Produces an oversample tick, a bit tick and a mid-bit tick from a
// fixed-point divisor (integer:fraction). The fraction is realised by
// stretching an interval by one cycle whenever the fraction accumulator
// carries. A reloaded divisor waits in a shadow register and is applied
// on a bit boundary, while disabled, or on sync.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : uart_baud_gen_frac_if slave modport (controls in, ticks out)
module uart_baud_gen_frac #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned DEFAULT_BAUD = 9600,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned DIV_WIDTH    = 16,
  parameter int unsigned FRAC_BITS    = 4,
  parameter logic [DIV_WIDTH+FRAC_BITS-1:0] DEFAULT_DIV =
    (DIV_WIDTH+FRAC_BITS)'(
      (64'(CLK_FREQ) * (64'd1 << FRAC_BITS) * 64'd2
       + 64'(DEFAULT_BAUD) * 64'(OVERSAMPLE))
      / (64'(DEFAULT_BAUD) * 64'(OVERSAMPLE) * 64'd2))
) (
  input logic                 clk,
  input logic                 reset,
  uart_baud_gen_frac_if.slave bus
);

  localparam int unsigned TW  = DIV_WIDTH + FRAC_BITS;
  localparam int unsigned CW  = DIV_WIDTH + 1;
  localparam int unsigned OSW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  logic [TW-1:0]        div_active_q;
  logic [TW-1:0]        shadow_q;
  logic                 pending_q;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic [OSW-1:0]       os_cnt_q;
  logic [FRAC_BITS-1:0] acc_q;
  logic                 os_q;
  logic                 bit_q;
  logic                 mid_q;

  logic [DIV_WIDTH-1:0] int_part;
  logic [DIV_WIDTH-1:0] int_eff;
  logic [FRAC_BITS-1:0] frac;
  logic [FRAC_BITS:0]   sum;
  logic [CW-1:0]        last_cnt;
  logic                 run;
  logic                 wrap;
  logic                 bit_wrap;
  logic                 mid_wrap;
  logic                 apply;

  always_comb begin
    int_part = div_active_q[TW-1:FRAC_BITS];
    frac     = div_active_q[FRAC_BITS-1:0];
    int_eff  = (int_part == '0) ? DIV_WIDTH'(1) : int_part;
    sum      = {1'b0, acc_q} + {1'b0, frac};
    // Interval length is I plus the accumulator carry; compare against P-1.
    last_cnt = {1'b0, int_eff} + CW'(sum[FRAC_BITS]) - CW'(1);
    run      = bus.en & ~bus.sync;
    wrap     = run & ({1'b0, cnt_q} == last_cnt);
    bit_wrap = wrap & (os_cnt_q == OSW'(OVERSAMPLE - 1));
    mid_wrap = wrap & (os_cnt_q == OSW'(OVERSAMPLE / 2 - 1));
    apply    = ~bus.en | bus.sync | bit_wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_active_q <= DEFAULT_DIV;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      cnt_q        <= '0;
      os_cnt_q     <= '0;
      acc_q        <= '0;
      os_q         <= 1'b0;
      bit_q        <= 1'b0;
      mid_q        <= 1'b0;
    end else begin
      os_q  <= wrap;
      bit_q <= bit_wrap;
      mid_q <= mid_wrap;

      if (!run) begin
        cnt_q    <= '0;
        os_cnt_q <= '0;
        acc_q    <= '0;
      end else if (wrap) begin
        cnt_q    <= '0;
        os_cnt_q <= bit_wrap ? '0 : os_cnt_q + OSW'(1);
        acc_q    <= sum[FRAC_BITS-1:0];
      end else begin
        cnt_q <= cnt_q + DIV_WIDTH'(1);
      end

      // A load coinciding with an apply bypasses the shadow; the accumulator
      // restarts so the new fraction pattern begins from a clean phase.
      if (apply && bus.div_load) begin
        div_active_q <= bus.div_in;
        pending_q    <= 1'b0;
        acc_q        <= '0;
      end else if (apply && pending_q) begin
        div_active_q <= shadow_q;
        pending_q    <= 1'b0;
        acc_q        <= '0;
      end else if (bus.div_load) begin
        shadow_q  <= bus.div_in;
        pending_q <= 1'b1;
      end
    end
  end

  assign bus.os_tick     = os_q;
  assign bus.bit_tick    = bit_q;
  assign bus.mid_tick    = mid_q;
  assign bus.cfg_pending = pending_q;
  assign bus.div_active  = div_active_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
module tb_uart_baud_gen_frac;

  localparam int unsigned OS4   = 4;
  localparam int unsigned FB    = 4;
  localparam logic [19:0] DEF4  = 20'd20833; // 50e6*16/(9600*4)  = 20833.33
  localparam logic [19:0] DEF16 = 20'd5208;  // 50e6*16/(9600*16) = 5208.33

  logic clk = 1'b0;
  logic rst4 = 1'b1;
  logic rst16 = 1'b1;
  always #5 clk = ~clk;

  uart_baud_gen_frac_if #(.DIV_WIDTH(16), .FRAC_BITS(4)) bus4 ();
  uart_baud_gen_frac_if #(.DIV_WIDTH(16), .FRAC_BITS(4)) bus16 ();

  uart_baud_gen_frac #(.OVERSAMPLE(4)) dut4 (.clk(clk), .reset(rst4), .bus(bus4));
  uart_baud_gen_frac dut16 (.clk(clk), .reset(rst16), .bus(bus16));

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] snap4();
    return {bus4.os_tick, bus4.bit_tick, bus4.mid_tick, bus4.cfg_pending, bus4.div_active};
  endfunction

  function automatic logic [23:0] snap16();
    return {bus16.os_tick, bus16.bit_tick, bus16.mid_tick, bus16.cfg_pending, bus16.div_active};
  endfunction

  // Directed vectors: inputs held across one edge, outputs expected after it.
  typedef struct {
    bit rst, en, sync, ld;
    logic [19:0] din;
    bit os, bt, md, pd;
    logic [19:0] div;
  } vec_t;
  vec_t vecs[$];

  task automatic v(input bit r, e, s, l, input logic [19:0] d,
                   input bit o, b, m, p, input logic [19:0] dv);
    vec_t t;
    t.rst = r; t.en = e; t.sync = s; t.ld = l; t.din = d;
    t.os = o; t.bt = b; t.md = m; t.pd = p; t.div = dv;
    vecs.push_back(t);
  endtask

  // Reference model: interval k since the last accumulator restart lasts
  // I + floor((k+1)F/2^FB) - floor(kF/2^FB) cycles; tick role from k mod OS.
  bit          m_os, m_bit, m_mid, m_pend;
  logic [19:0] m_div, m_shadow;
  int unsigned m_el, m_kacc, m_kos;

  task automatic model_step(input bit r, e, s, l, input logic [19:0] din);
    int unsigned ii, ff, pp;
    bit wrap, bitw, app;
    if (r) begin
      m_os = 0; m_bit = 0; m_mid = 0; m_pend = 0;
      m_div = DEF4; m_shadow = '0; m_el = 0; m_kacc = 0; m_kos = 0;
      return;
    end
    ii = int'(m_div) / (1 << FB);
    if (ii == 0) ii = 1;
    ff = int'(m_div) % (1 << FB);
    pp = ii + ((m_kacc + 1) * ff) / (1 << FB) - (m_kacc * ff) / (1 << FB);
    wrap  = e && !s && (m_el == pp - 1);
    bitw  = wrap && (m_kos == OS4 - 1);
    m_os  = wrap;
    m_bit = bitw;
    m_mid = wrap && (m_kos == OS4 / 2 - 1);
    if (!e || s) begin
      m_el = 0; m_kacc = 0; m_kos = 0;
    end else if (wrap) begin
      m_el = 0; m_kacc = (m_kacc + 1) % (1 << FB); m_kos = (m_kos + 1) % OS4;
    end else begin
      m_el++;
    end
    app = !e || s || bitw;
    if (app && l) begin
      m_div = din; m_pend = 0; m_kacc = 0;
    end else if (app && m_pend) begin
      m_div = m_shadow; m_pend = 0; m_kacc = 0;
    end else if (l) begin
      m_shadow = din; m_pend = 1;
    end
  endtask

  initial begin
    int unsigned n, ticks;
    bit r, e, s, l;
    logic [19:0] d;

    bus4.en = 0; bus4.sync = 0; bus4.div_load = 0; bus4.div_in = '0;
    bus16.en = 0; bus16.sync = 0; bus16.div_load = 0; bus16.div_in = '0;

    //  rst en sy ld din      os bt md pd div
    v(1, 0, 0, 0, 20'h0,    0, 0, 0, 0, DEF4);
    v(0, 0, 0, 1, 20'h40,   0, 0, 0, 0, 20'h40);  // load while disabled: direct
    v(0, 1, 0, 0, 20'h0,    0, 0, 0, 0, 20'h40);
    v(0, 1, 0, 0, 20'h0,    0, 0, 0, 0, 20'h40);
    v(0, 1, 0, 0, 20'h0,    0, 0, 0, 0, 20'h40);
    v(0, 1, 0, 0, 20'h0,    1, 0, 0, 0, 20'h40);  // first os_tick at 4th edge
    v(0, 1, 0, 1, 20'h48,   0, 0, 0, 1, 20'h40);  // mid-bit load -> pending
    v(0, 1, 0, 0, 20'h0,    0, 0, 0, 1, 20'h40);
    v(0, 1, 0, 0, 20'h0,    0, 0, 0, 1, 20'h40);
    v(0, 1, 0, 0, 20'h0,    1, 0, 1, 1, 20'h40);  // 2nd os_tick = mid
    for (int i = 0; i < 3; i++) v(0, 1, 0, 0, 20'h0, 0, 0, 0, 1, 20'h40);
    v(0, 1, 0, 0, 20'h0,    1, 0, 0, 1, 20'h40);
    for (int i = 0; i < 3; i++) v(0, 1, 0, 0, 20'h0, 0, 0, 0, 1, 20'h40);
    v(0, 1, 0, 0, 20'h0,    1, 1, 0, 0, 20'h48);  // bit_tick applies shadow
    for (int i = 0; i < 3; i++) v(0, 1, 0, 0, 20'h0, 0, 0, 0, 0, 20'h48);
    v(0, 1, 0, 0, 20'h0,    1, 0, 0, 0, 20'h48);  // 4.5: interval 4
    for (int i = 0; i < 4; i++) v(0, 1, 0, 0, 20'h0, 0, 0, 0, 0, 20'h48);
    v(0, 1, 0, 0, 20'h0,    1, 0, 1, 0, 20'h48);  // then interval 5
    v(0, 1, 1, 0, 20'h0,    0, 0, 0, 0, 20'h48);  // sync: no tick next cycle
    for (int i = 0; i < 3; i++) v(0, 1, 0, 0, 20'h0, 0, 0, 0, 0, 20'h48);
    v(0, 1, 0, 0, 20'h0,    1, 0, 0, 0, 20'h48);  // P after sync, os_cnt 0
    v(0, 0, 0, 1, 20'h0,    0, 0, 0, 0, 20'h0);   // I=0,F=0 -> every cycle
    v(0, 1, 0, 0, 20'h0,    1, 0, 0, 0, 20'h0);
    v(0, 1, 0, 0, 20'h0,    1, 0, 1, 0, 20'h0);
    v(0, 1, 0, 0, 20'h0,    1, 0, 0, 0, 20'h0);
    v(0, 1, 0, 0, 20'h0,    1, 1, 0, 0, 20'h0);
    v(1, 1, 0, 0, 20'h0,    0, 0, 0, 0, DEF4);    // reset while ticking

    foreach (vecs[i]) begin
      rst4 = vecs[i].rst; bus4.en = vecs[i].en; bus4.sync = vecs[i].sync;
      bus4.div_load = vecs[i].ld; bus4.div_in = vecs[i].din;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), 32'(snap4()),
            32'({vecs[i].os, vecs[i].bt, vecs[i].md, vecs[i].pd, vecs[i].div}));
    end

    // 4.5 divisor: 32 os_ticks must span exactly 144 cycles.
    rst4 = 0; bus4.en = 0; bus4.sync = 0; bus4.div_load = 1; bus4.div_in = 20'h48;
    @(posedge clk); #1;
    bus4.div_load = 0;
    check("frac_load", 32'(bus4.div_active), 32'h48);
    bus4.en = 1;
    n = 0; ticks = 0;
    while (ticks < 32 && n < 1000) begin
      @(posedge clk); #1; n++;
      if (bus4.os_tick) ticks++;
    end
    check("frac_span", n, 144);

    // en dropped mid-bit with a pending load.
    repeat (5) @(posedge clk);
    #1;
    bus4.div_load = 1; bus4.div_in = 20'h60;
    @(posedge clk); #1;
    bus4.div_load = 0;
    check("drop_pend", 32'(bus4.cfg_pending), 1);
    bus4.en = 0;
    @(posedge clk); #1;
    check("drop_state", 32'(snap4()), 32'({4'b0000, 20'h60}));
    bus4.en = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus4.os_tick && n < 100);
    check("drop_first_tick", n, 6);

    // Randomised run against the model.
    rst4 = 1; bus4.en = 0; bus4.sync = 0; bus4.div_load = 0;
    @(posedge clk); model_step(1, 0, 0, 0, '0); #1;
    check("rand_reset", 32'(snap4()), 32'({m_os, m_bit, m_mid, m_pend, m_div}));
    rst4 = 0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 499) == 0);
      e = ($urandom_range(0, 99) >= 4);
      s = ($urandom_range(0, 99) == 0);
      l = ($urandom_range(0, 99) < 3);
      d = {16'($urandom_range(0, 6)), 4'($urandom_range(0, 15))};
      rst4 = r; bus4.en = e; bus4.sync = s; bus4.div_load = l; bus4.div_in = d;
      @(posedge clk); model_step(r, e, s, l, d); #1;
      check($sformatf("rand%0d", i), 32'(snap4()),
            32'({m_os, m_bit, m_mid, m_pend, m_div}));
    end
    rst4 = 1; bus4.en = 0; bus4.sync = 0; bus4.div_load = 0;

    // Default 50 MHz / 9600 / 16x instance.
    @(posedge clk); #1;
    check("def_reset", 32'(snap16()), 32'({4'b0000, DEF16}));
    rst16 = 0; bus16.en = 1;
    for (int b = 0; b < 2; b++) begin
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!bus16.bit_tick && n < 6000);
      check($sformatf("def_bit%0d", b), n, 5208);
    end
    repeat (100) @(posedge clk);
    #1;
    bus16.div_load = 1; bus16.div_in = 20'h12345;
    @(posedge clk); #1;
    bus16.div_load = 0;
    check("def_pend", 32'(bus16.cfg_pending), 1);
    rst16 = 1;
    @(posedge clk); #1;
    check("def_midreset", 32'(snap16()), 32'({4'b0000, DEF16}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen_frac.md
Name: uart_baud_gen_frac

Overview:
Programmable fractional baud-rate generator for the UART TX/RX pair, succeeding the fixed half-baud tick generator. It produces an oversample tick, a bit tick and a mid-bit sample tick. The divisor has integer and fractional parts and can be reloaded at run time, with the change applied glitch-free on a bit boundary. A resync input lets the RX start-bit detector align tick phase to the incoming edge.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
DEFAULT_BAUD, 9600, baud rate loaded at reset
OVERSAMPLE, 16, oversample ticks per bit; even, >= 4
DIV_WIDTH, 16, integer-divisor width
FRAC_BITS, 4, fractional-divisor width
DEFAULT_DIV, round(CLK_FREQ*2^FRAC_BITS/(DEFAULT_BAUD*OVERSAMPLE)), reset divisor in fixed point; upper DIV_WIDTH bits are integer, lower FRAC_BITS bits are fraction

Ports:
clk, input, 1, system clock, rising edge
reset, input, 1, synchronous, active-high reset
en, input, 1, generator enable
sync, input, 1, one-cycle pulse that restarts the tick phase
div_in, input, DIV_WIDTH+FRAC_BITS, new divisor (integer:fraction)
div_load, input, 1, one-cycle strobe that captures div_in into the shadow register
os_tick, output, 1, one-cycle oversample tick
bit_tick, output, 1, one-cycle tick on the last oversample of each bit
mid_tick, output, 1, one-cycle tick at the mid-bit sample point
cfg_pending, output, 1, shadow divisor waiting to be applied
div_active, output, DIV_WIDTH+FRAC_BITS, divisor currently in use

Behaviour:
- One clock domain and one clock, clk. reset is synchronous and active-high.
- Reset values: os_tick, bit_tick, mid_tick and cfg_pending are 0. div_active is DEFAULT_DIV. The cycle counter, oversample counter and fraction accumulator are 0. The shadow register is discarded.
- Integer part I = div_active[high]. I = 0 is treated as 1. Fraction F = div_active[FRAC_BITS-1:0].
- Interval k runs from one os_tick to the next. Its period P_k = I + carry, where carry is the carry-out of (acc + F) in FRAC_BITS bits and acc is the accumulator value at the start of the interval. At the end of the interval, acc <= (acc + F) mod 2^FRAC_BITS.
- The cycle counter counts from 0 to P_k-1. os_tick is registered and is high in the cycle after the counter reaches P_k-1. With en=1 from reset release, the first os_tick is at the P_0-th rising edge after release.
- The oversample counter os_cnt runs 0..OVERSAMPLE-1 and advances on each os_tick.
  - bit_tick = os_tick AND os_cnt == OVERSAMPLE-1 (value before the increment).
  - mid_tick = os_tick AND os_cnt == OVERSAMPLE/2-1.
- Ticks are always single-cycle. When I = 1 and F = 0, os_tick is high every cycle.
- en = 0: all counters and acc are held at 0 and no ticks are issued. When en rises, timing is the same as after reset release.
- div_load: div_in is captured into the shadow register and cfg_pending <= 1. A later load overwrites a still-pending value.
- Applying the shadow: div_active <= shadow, acc <= 0, cfg_pending <= 0. This happens in the cycle bit_tick is issued (new period from the next interval), in any cycle with en = 0, or on sync.
- div_load in the same cycle as an apply: div_in is applied directly and cfg_pending stays 0.
- sync = 1: the cycle counter, os_cnt and acc are cleared and no tick is issued in the following cycle. The next os_tick comes P cycles after sync. sync has priority over a simultaneous tick or counter wrap. sync while en = 0 is ignored apart from applying a pending shadow.
- reset asserted mid-bit: all state returns to reset values on that edge, with no trailing tick.

Test Plan:
- OVERSAMPLE=4, div_load with I=4, F=0, then sync → os_tick every 4 cycles, bit_tick every 16 cycles on the 4th os_tick, mid_tick on the 2nd os_tick.
- FRAC_BITS=4, I=4, F=8 (4.5) → os_tick intervals 4,5,4,5,…; 32 os_ticks span exactly 144 cycles.
- div_load with I=6 issued mid-bit → cfg_pending=1 until bit_tick, div_active changes in that cycle, the next interval is 6 cycles, and intervals before bit_tick keep the old period.
- sync asserted one cycle before a scheduled bit_tick → no tick in the cycle after sync; next os_tick P cycles later with os_cnt=0; mid_tick after OVERSAMPLE/2 os_ticks.
- en dropped mid-bit with a pending load → ticks stop immediately, shadow applied, cfg_pending=0; after en rises the first os_tick is at the new P.
- Defaults (50 MHz, 9600, 16x) → DEFAULT_DIV=325.5 (5208); bit period averages 5208 cycles over 16 bits. reset mid-operation clears all outputs and restores DEFAULT_DIV.
